debounce_pulse: RTL and testbench
=================================

DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter DB_CYCLES, default 16, sets the number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 Port in  input  1  raw, asynchronous, bouncing switch/button level.
REQ-005 Port pulse  output  1  registered one-cycle press strobe; this is the pulse consumed by the downstream pulse-to-toggle stage.
REQ-006 Port release  output  1  registered one-cycle strobe on an accepted release.
REQ-007 Port level  output  1  registered debounced level of in.

Function
REQ-008 Input is passed through a two-flop synchronizer; sync_in is the second-stage output, so it lags in by 2 clock edges.
REQ-009 Counter cnt is $clog2(DB_CYCLES+1) bits wide, unsigned, and never wraps; it saturates at DB_CYCLES.
REQ-010 FSM states: IDLE, RISE_WAIT, HIGH, FALL_WAIT.
REQ-011 IDLE: sync_in=1 -> RISE_WAIT with cnt=1; otherwise stay, cnt=0.
REQ-012 RISE_WAIT, sync_in=0: -> IDLE, cnt=0, no strobe.
REQ-013 RISE_WAIT, sync_in=1, cnt<DB_CYCLES: cnt increments.
REQ-014 RISE_WAIT, sync_in=1, cnt=DB_CYCLES: -> HIGH, cnt=0, pulse=1 for exactly the following cycle.
REQ-015 HIGH: sync_in=0 -> FALL_WAIT with cnt=1; otherwise stay, cnt=0.
REQ-016 FALL_WAIT, sync_in=1: -> HIGH, cnt=0, no strobe.
REQ-017 FALL_WAIT, sync_in=0, cnt<DB_CYCLES: cnt increments.
REQ-018 FALL_WAIT, sync_in=0, cnt=DB_CYCLES: -> IDLE, cnt=0, release=1 for exactly the following cycle.
REQ-019 level is 1 exactly when the registered state is HIGH or FALL_WAIT.
REQ-020 Latency: if edge k is the first edge sampling in=1 and in is held stable, pulse and level rise in the cycle after edge k+DB_CYCLES+2; release timing is symmetric.
REQ-021 pulse and release are never both 1 in the same cycle, and neither is ever high for more than one consecutive cycle.
REQ-022 Any bounce shorter than DB_CYCLES synchronized samples produces no strobe and no level change.
REQ-023 No idle strobes: a held input yields exactly one pulse per accepted press.

Reset
REQ-024 While reset=0: synchronizer flops, cnt, pulse, release and level are 0, and state is IDLE.
REQ-025 Reset asserted mid-debounce abandons the count with no strobe.
REQ-026 An input already high at reset release is debounced from scratch and yields exactly one pulse per REQ-020 (k = first edge after release).

Structure
REQ-027 State encodings (IDLE=2'd0, RISE_WAIT=2'd1, HIGH=2'd2, FALL_WAIT=2'd3) and the DB_CYCLES default belong in the shared lab package/header.
REQ-028 The two-flop synchronizer is a separate sub-module sync2 (clock, reset, d, q) with the same active-low asynchronous reset.
REQ-029 Estimated RTL size: 120-250 lines including sync2.

Verification (DB_CYCLES=4)
REQ-030 Clean press: reset released, in 0->1 sampled at edge 10 and held -> pulse=1 only in the cycle after edge 16; level=1 from that cycle onward.
REQ-031 Bounce reject: in high for 3 cycles then low, repeated 5 times -> pulse, release and level stay 0 throughout.
REQ-032 Clean release: from level=1, in 1->0 sampled at edge 40 and held -> release=1 only in the cycle after edge 46; level=0 from that cycle onward.
REQ-033 Release glitch: from HIGH, in low for 2 cycles then high -> level stays 1 and no strobes occur.
REQ-034 Reset mid-debounce: reset=0 asserted 2 cycles into RISE_WAIT -> all outputs 0 immediately; in still high at release -> exactly one pulse 7 edges after release.
REQ-035 Long hold: in held high for 1000 cycles -> exactly one pulse and zero release strobes.

Source files
------------

// File: rtl/debounce_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse_pkg
// Description : Shared state encoding and default debounce length for the
//               button debounce / press-strobe block.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pulse_pkg;

    // Default number of consecutive stable synchronized samples
    localparam int unsigned c_db_cycles_default = 16;

    // Debounce FSM state encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse_if
// Description : Raw button input and debounced strobes/level bundle.
//               master = the side that owns the button and consumes strobes,
//               slave  = the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_pulse_if;

    logic i_in;       // raw asynchronous bouncing level
    logic o_pulse;    // one-cycle strobe on accepted press
    logic o_release;  // one-cycle strobe on accepted release
    logic o_level;    // debounced level

    modport master (
        output i_in,
        input  o_pulse,
        input  o_release,
        input  o_level
    );

    modport slave (
        input  i_in,
        output o_pulse,
        output o_release,
        output o_level
    );

endinterface
`default_nettype wire

// File: rtl/debounce_pulse_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single asynchronous bit, with
//               asynchronous active-low reset clearing both stages.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic d,
    output logic      q
);

    logic [1:0] r_sync;

    // Shift the raw input through two flops to resolve metastability
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse
// Description : Button debouncer. The raw input is synchronized, then a level
//               change is accepted only after it stays stable for DB_CYCLES
//               more samples beyond the first differing one. Emits a
//               one-cycle press strobe, a one-cycle release strobe and the
//               debounced level, all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int unsigned DB_CYCLES = c_db_cycles_default
) (
    input  wire logic       clock,
    input  wire logic       reset,
    debounce_pulse_if.slave bus
);

    localparam int unsigned             c_cnt_w   = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]      c_cnt_max = c_cnt_w'(DB_CYCLES);
    localparam logic [c_cnt_w-1:0]      c_cnt_one = c_cnt_w'(1);

    logic               w_sync_in;
    db_state_t          r_state;
    db_state_t          w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_pulse_next;
    logic               w_release_next;
    logic               w_level_next;
    logic               r_pulse;
    logic               r_release;
    logic               r_level;

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (bus.i_in),
        .q     (w_sync_in)
    );

    // State, counter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_pulse   <= w_pulse_next;
            r_release <= w_release_next;
            r_level   <= w_level_next;
        end
    end

    // Next-state logic; the counter only runs while a change is pending and
    // the transition fires on the sample where it has already reached
    // DB_CYCLES, so it never exceeds DB_CYCLES.
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = '0;
        w_pulse_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync_in) begin
                    w_next_state = RISE_WAIT;
                    w_cnt_next   = c_cnt_one;
                end
            end
            RISE_WAIT: begin
                if (!w_sync_in) begin
                    w_next_state = IDLE;
                end else if (r_cnt == c_cnt_max) begin
                    w_next_state = HIGH;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            HIGH: begin
                if (!w_sync_in) begin
                    w_next_state = FALL_WAIT;
                    w_cnt_next   = c_cnt_one;
                end
            end
            FALL_WAIT: begin
                if (w_sync_in) begin
                    w_next_state = HIGH;
                end else if (r_cnt == c_cnt_max) begin
                    w_next_state   = IDLE;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Level tracks the state register, so register its next value
        w_level_next = (w_next_state == HIGH) || (w_next_state == FALL_WAIT);
    end

    assign bus.o_pulse   = r_pulse;
    assign bus.o_release = r_release;
    assign bus.o_level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_pulse
// Description : Self-checking bench for debounce_pulse (DB_CYCLES = 4).
//               Directed scenarios plus randomized bouncing input, compared
//               every cycle against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_pulse;

    localparam int DB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    debounce_pulse_if u_bus ();

    debounce_pulse #(.DB_CYCLES(DB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_bus.slave)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model: two-sample delay line, accepted level and the length
    // of the current run of samples that disagree with the accepted level.
    bit m_s1, m_s2, m_lvl, m_pulse, m_rel;
    int m_run;

    int n_pulse, n_rel, first_pulse_edge, first_rel_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_pulse = 0; m_rel = 0;
    endtask

    // One rising edge of the model: a change is accepted on the
    // (DB+1)-th consecutive synchronized sample that disagrees.
    task automatic model_edge();
        bit s;
        if (!reset) begin
            model_reset();
        end else begin
            s       = m_s2;
            m_s2    = m_s1;
            m_s1    = u_bus.i_in;
            m_pulse = 0;
            m_rel   = 0;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_lvl = s;
                    m_run = 0;
                    if (s) m_pulse = 1;
                    else   m_rel   = 1;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic clear_stats();
        n_pulse = 0; n_rel = 0; first_pulse_edge = -1; first_rel_edge = -1;
    endtask

    // Drive the input ahead of the edge, then check 1 time unit after it
    task automatic tick(input logic v);
        u_bus.i_in = v;
        @(posedge clock);
        #1;
        edge_n++;
        model_edge();
        chk("pulse",   u_bus.o_pulse,   m_pulse);
        chk("release", u_bus.o_release, m_rel);
        chk("level",   u_bus.o_level,   m_lvl);
        if (u_bus.o_pulse) begin
            n_pulse++;
            if (first_pulse_edge < 0) first_pulse_edge = edge_n;
        end
        if (u_bus.o_release) begin
            n_rel++;
            if (first_rel_edge < 0) first_rel_edge = edge_n;
        end
        @(negedge clock);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_pulse",   u_bus.o_pulse,   0);
        chk("rst_release", u_bus.o_release, 0);
        chk("rst_level",   u_bus.o_level,   0);
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        u_bus.i_in = 1'b0;
        model_reset();
        clear_stats();
        #2;
        assert_reset();
        @(negedge clock);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);

        // Clean press at edge 10, clean release at edge 40
        release_reset();
        clear_stats();
        for (int e = 1; e <= 55; e++) tick((e >= 10) && (e < 40));
        chk("press_edge",   first_pulse_edge, 16);
        chk("release_edge", first_rel_edge,   46);
        chk("press_count",  n_pulse, 1);
        chk("rel_count",    n_rel,   1);

        // Bounce reject: short high bursts
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            repeat (3) tick(1'b1);
            repeat (3) tick(1'b0);
        end
        repeat (6) tick(1'b0);
        chk("bounce_pulses", n_pulse, 0);
        chk("bounce_rels",   n_rel,   0);
        chk("bounce_level",  u_bus.o_level, 0);

        // Release glitch from HIGH
        repeat (12) tick(1'b1);
        clear_stats();
        repeat (2) tick(1'b0);
        repeat (12) tick(1'b1);
        chk("glitch_pulses", n_pulse, 0);
        chk("glitch_rels",   n_rel,   0);
        chk("glitch_level",  u_bus.o_level, 1);

        // Reset two cycles into RISE_WAIT, input still high at release
        repeat (15) tick(1'b0);
        repeat (4) tick(1'b1);
        assert_reset();
        repeat (2) tick(1'b1);
        release_reset();
        clear_stats();
        repeat (12) tick(1'b1);
        chk("rst_press_edge",  first_pulse_edge, 7);
        chk("rst_press_count", n_pulse, 1);

        // Long hold
        repeat (15) tick(1'b0);
        clear_stats();
        repeat (1000) tick(1'b1);
        chk("hold_pulses", n_pulse, 1);
        chk("hold_rels",   n_rel,   0);

        // Randomized bouncing input with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DB + 3);
            repeat (len) tick(v);
            if ($urandom_range(0, 49) == 0) begin
                assert_reset();
                repeat ($urandom_range(1, 3)) tick(1'($urandom_range(0, 1)));
                release_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
